prime_round_ctrl: RTL and testbench

Round sequencer for the prime-prediction game. It accepts a player's prediction, requests the next prime from the LFSR prime generator by pulsing its enable with the current score, and waits a fixed latency before capturing the generator output. It then judges the prediction and keeps the score and round count. It sits between the player-input logic and the generator, and it is the only driver of the generator's `enable` and `score` inputs.

---
 rtl/prime_round_ctrl.sv | 152 +++++++++++++++
 tb/tb_prime_round_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_round_ctrl.sv
// Round sequencer for the prime-prediction game.
// Takes a guess, pulses the generator, captures its prime and scores the round.
module prime_round_ctrl #(
  parameter int ROUNDS  = 8,
  parameter int GEN_LAT = 4,
  parameter int TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] guess,
  input  logic       guess_valid,
  output logic       guess_ready,
  output logic       gen_enable,
  output logic [6:0] gen_score,
  input  logic [6:0] gen_prime,
  output logic [6:0] prime_out,
  output logic       result_valid,
  output logic       hit,
  output logic       timed_out,
  output logic [6:0] score,
  output logic [3:0] round,
  output logic       busy,
  output logic       done
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = $clog2(GEN_LAT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GUESS = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_JUDGE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [6:0]    guess_q, guess_d;
  logic          to_q, to_d;
  logic [6:0]    prime_q, prime_d;
  logic [6:0]    score_q, score_d;
  logic [3:0]    round_q, round_d;

  logic          ready_q, gen_en_q, rv_q;
  logic          hit_q, tout_q, busy_q, done_q;
  logic [6:0]    gen_score_q;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    wcnt_d  = wcnt_q;
    guess_d = guess_q;
    to_d    = to_q;
    prime_d = prime_q;
    score_d = score_q;
    round_d = round_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          score_d = '0;
          round_d = '0;
          tcnt_d  = '0;
          state_d = S_GUESS;
        end
      end
      S_GUESS: begin
        tcnt_d = tcnt_q + 1'b1;
        if (guess_valid) begin
          guess_d = guess;
          to_d    = 1'b0;
          state_d = S_REQ;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          guess_d = '0;
          to_d    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == WW'(GEN_LAT - 1)) begin
          prime_d = gen_prime;
          state_d = S_JUDGE;
        end
      end
      S_JUDGE: begin
        if (hit_q && score_q != 7'd127) score_d = score_q + 7'd1;
        round_d = round_q + 4'd1;
        tcnt_d  = '0;
        state_d = (round_d == 4'(ROUNDS)) ? S_DONE : S_GUESS;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port is a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      wcnt_q      <= '0;
      guess_q     <= '0;
      to_q        <= 1'b0;
      prime_q     <= '0;
      score_q     <= '0;
      round_q     <= '0;
      ready_q     <= 1'b0;
      gen_en_q    <= 1'b0;
      gen_score_q <= '0;
      rv_q        <= 1'b0;
      hit_q       <= 1'b0;
      tout_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      wcnt_q   <= wcnt_d;
      guess_q  <= guess_d;
      to_q     <= to_d;
      prime_q  <= prime_d;
      score_q  <= score_d;
      round_q  <= round_d;
      ready_q  <= (state_d == S_GUESS);
      gen_en_q <= (state_d == S_REQ);
      if (state_d == S_REQ) gen_score_q <= score_q;
      rv_q     <= (state_d == S_JUDGE);
      hit_q    <= (state_d == S_JUDGE) && !to_d && (guess_d == prime_d);
      tout_q   <= (state_d == S_JUDGE) && to_d;
      busy_q   <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign guess_ready  = ready_q;
  assign gen_enable   = gen_en_q;
  assign gen_score    = gen_score_q;
  assign prime_out    = prime_q;
  assign result_valid = rv_q;
  assign hit          = hit_q;
  assign timed_out    = tout_q;
  assign score        = score_q;
  assign round        = round_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_prime_round_ctrl.sv
// Directed bench for prime_round_ctrl with a fixed-latency generator model.
// Inputs change and outputs are sampled on the falling edge.
module tb_prime_round_ctrl;

  localparam int GL = 4;
  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [6:0] guess = '0;
  logic       guess_valid = 1'b0;
  logic       guess_ready;
  logic       gen_enable;
  logic [6:0] gen_score;
  logic [6:0] gen_prime = '0;
  logic [6:0] prime_out;
  logic       result_valid;
  logic       hit;
  logic       timed_out;
  logic [6:0] score;
  logic [3:0] round;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int n_gen = 0;
  int n_res = 0;
  int gcnt = 0;
  logic [6:0] next_prime = '0;

  always #5 clk = ~clk;

  prime_round_ctrl #(.ROUNDS(8), .GEN_LAT(GL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .guess(guess), .guess_valid(guess_valid),
    .guess_ready(guess_ready), .gen_enable(gen_enable),
    .gen_score(gen_score), .gen_prime(gen_prime),
    .prime_out(prime_out), .result_valid(result_valid),
    .hit(hit), .timed_out(timed_out), .score(score),
    .round(round), .busy(busy), .done(done)
  );

  // Generator: output becomes valid GL cycles after the enable pulse.
  always @(posedge clk) begin
    if (gen_enable) begin
      gen_prime <= '0;
      gcnt      <= GL - 1;
    end else if (gcnt > 0) begin
      gcnt <= gcnt - 1;
      if (gcnt == 1) gen_prime <= next_prime;
    end
  end

  always @(posedge clk) begin
    if (gen_enable)   n_gen <= n_gen + 1;
    if (result_valid) n_res <= n_res + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic play(input bit use_g, input int dly,
                      input logic [6:0] g, input logic [6:0] p,
                      output int lat, output logic r_hit,
                      output logic r_to, output logic [6:0] r_prime,
                      output logic r_ge, output logic [6:0] r_gs);
    int n;
    next_prime = p;
    n = 0;
    while (!guess_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!guess_ready) check("ready_wait", 0, 1);
    repeat (dly) @(negedge clk);
    if (use_g) begin
      guess = g;
      guess_valid = 1'b1;
    end
    @(negedge clk);
    guess_valid = 1'b0;
    r_ge = gen_enable;
    r_gs = gen_score;
    lat = 1;
    while (!result_valid && lat < TO + 40) begin
      @(negedge clk);
      lat++;
    end
    if (!result_valid) check("result_wait", 0, 1);
    r_hit = hit;
    r_to = timed_out;
    r_prime = prime_out;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int lat, g0, r0;
    logic h, t, ge;
    logic [6:0] pr, gs;

    repeat (2) @(negedge clk);
    check("rst_score", score, 0);
    check("rst_round", round, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", guess_ready, 0);
    check("rst_genen", gen_enable, 0);
    check("rst_rv", result_valid, 0);
    rst = 1'b1;
    @(negedge clk);

    // Reset during WAIT
    pulse_start();
    check("start_ready", guess_ready, 1);
    check("start_busy", busy, 1);
    guess = 7'd5;
    guess_valid = 1'b1;
    @(negedge clk);
    guess_valid = 1'b0;
    check("mid_genen", gen_enable, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_genen", gen_enable, 0);
    check("arst_ready", guess_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    g0 = n_gen;
    r0 = n_res;
    repeat (20) @(negedge clk);
    check("arst_no_gen", n_gen - g0, 0);
    check("arst_no_res", n_res - r0, 0);
    check("arst_idle_busy", busy, 0);

    // Round 1: hit on 13
    pulse_start();
    g0 = n_gen;
    play(1, 0, 7'd13, 7'd13, lat, h, t, pr, ge, gs);
    check("hit_genen", ge, 1);
    check("hit_gscore", gs, 0);
    check("hit_lat", lat, 6);
    check("hit_hit", h, 1);
    check("hit_to", t, 0);
    check("hit_prime", pr, 13);
    check("hit_score", score, 1);
    check("hit_round", round, 1);
    check("hit_ready", guess_ready, 1);
    check("hit_rvlow", result_valid, 0);
    check("hit_hitlow", hit, 0);
    check("hit_npulse", n_gen - g0, 1);

    // Round 2: miss
    play(1, 0, 7'd11, 7'd17, lat, h, t, pr, ge, gs);
    check("miss_gscore", gs, 1);
    check("miss_hit", h, 0);
    check("miss_to", t, 0);
    check("miss_prime", pr, 17);
    check("miss_score", score, 1);
    check("miss_round", round, 2);

    // Round 3: timeout, generator returns 0 matching guess_q
    g0 = n_gen;
    play(0, 0, 7'd0, 7'd0, lat, h, t, pr, ge, gs);
    check("to_lat", lat, TO + GL + 1);
    check("to_to", t, 1);
    check("to_hit", h, 0);
    check("to_prime", pr, 0);
    check("to_npulse", n_gen - g0, 1);
    check("to_score", score, 1);
    check("to_round", round, 3);

    // Round 4: guess on the final GUESS cycle wins
    play(1, TO - 1, 7'd19, 7'd19, lat, h, t, pr, ge, gs);
    check("edge_lat", lat, 6);
    check("edge_to", t, 0);
    check("edge_hit", h, 1);
    check("edge_score", score, 2);

    // Round 5: guess one cycle late is ignored
    play(1, TO, 7'd23, 7'd23, lat, h, t, pr, ge, gs);
    check("late_to", t, 1);
    check("late_hit", h, 0);
    check("late_score", score, 2);
    check("late_round", round, 5);

    // start mid-game is ignored
    pulse_start();
    check("ign_start_round", round, 5);
    check("ign_start_score", score, 2);
    check("ign_start_busy", busy, 1);

    play(1, 0, 7'd29, 7'd29, lat, h, t, pr, ge, gs);
    check("r6_hit", h, 1);
    play(1, 0, 7'd31, 7'd31, lat, h, t, pr, ge, gs);
    check("r7_hit", h, 1);
    play(1, 2, 7'd37, 7'd37, lat, h, t, pr, ge, gs);
    check("r8_hit", h, 1);
    check("r8_gscore", gs, 4);
    check("game_done", done, 1);
    check("game_busy", busy, 0);
    check("game_score", score, 5);
    check("game_round", round, 8);
    check("game_ready", guess_ready, 0);
    repeat (5) @(negedge clk);
    check("hold_prime", prime_out, 37);
    check("hold_score", score, 5);
    check("hold_done", done, 1);

    pulse_start();
    check("restart_score", score, 0);
    check("restart_round", round, 0);
    check("restart_done", done, 0);
    check("restart_ready", guess_ready, 1);

    // Saturation: preload 126, then hit every round
    force dut.score_q = 7'd126;
    @(negedge clk);
    release dut.score_q;
    check("sat_preload", score, 126);
    play(1, 0, 7'd41, 7'd41, lat, h, t, pr, ge, gs);
    check("sat1_gscore", gs, 126);
    check("sat1_score", score, 127);
    play(1, 0, 7'd43, 7'd43, lat, h, t, pr, ge, gs);
    check("sat2_gscore", gs, 127);
    check("sat2_hit", h, 1);
    check("sat2_score", score, 127);
    play(1, 0, 7'd47, 7'd47, lat, h, t, pr, ge, gs);
    check("sat3_gscore", gs, 127);
    check("sat3_score", score, 127);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
